id_stage: RTL

Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage. It contains the IF/ID pipeline latch, the 32x32 register file, branch/jump resolution and the hazard unit. It consumes fetched ins/pc4. It returns bpc, rpc, jpc, PCSrc and a PC write-enable to the fetch-stage next-PC mux. It presents decoded operands to the ID/EX register.

---
 rtl/id_stage.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : MIPS instruction-decode stage. Holds the IF/ID latch, the 32x32
//             register file, branch/jump resolution with MEM forwarding, and
//             the hazard unit that stalls fetch and inserts bubbles.
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter logic [31:0] NOP_INS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc4,
    input  logic [31:0] if_ins,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        ex_we,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_wa,
    input  logic        mem_we,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_wa,
    input  logic [31:0] mem_alu,
    output logic [31:0] bpc,
    output logic [31:0] rpc,
    output logic [31:0] jpc,
    output logic [1:0]  PCSrc,
    output logic        pc_we,
    output logic        id_valid,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc4,
    output logic [31:0] id_rs_data,
    output logic [31:0] id_rt_data,
    output logic [31:0] id_imm
);

    // Opcodes and function codes resolved in this stage
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    // Next-PC mux select encodings
    localparam logic [1:0] c_PC_SEQ    = 2'd0;
    localparam logic [1:0] c_PC_BRANCH = 2'd1;
    localparam logic [1:0] c_PC_JR     = 2'd2;
    localparam logic [1:0] c_PC_JUMP   = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_ins;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [31:0] r_rf [0:31];

    // ------------------------------------------------------------------
    // Decode fields
    // ------------------------------------------------------------------
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [5:0]  w_funct;
    logic [31:0] w_imm;
    logic        w_is_beq;
    logic        w_is_bne;
    logic        w_is_jr;
    logic        w_is_jump;
    logic        w_is_ctl;
    logic        w_uses_rs;
    logic        w_uses_rt;

    assign w_op    = r_ins[31:26];
    assign w_rs    = r_ins[25:21];
    assign w_rt    = r_ins[20:16];
    assign w_funct = r_ins[5:0];
    assign w_imm   = {{16{r_ins[15]}}, r_ins[15:0]};

    assign w_is_beq  = (w_op == c_OP_BEQ);
    assign w_is_bne  = (w_op == c_OP_BNE);
    assign w_is_jr   = (w_op == c_OP_RTYPE) && (w_funct == c_FN_JR);
    assign w_is_jump = (w_op == c_OP_J) || (w_op == c_OP_JAL);

    // Instructions that compare or consume register values in ID need
    // their operands to be final here, not just by EX.
    assign w_is_ctl  = w_is_beq || w_is_bne || w_is_jr;
    assign w_uses_rs = w_is_ctl;
    assign w_uses_rt = w_is_beq || w_is_bne;

    // ------------------------------------------------------------------
    // Register file reads with same-cycle writeback bypass
    // ------------------------------------------------------------------
    logic [31:0] w_rs_rf;
    logic [31:0] w_rt_rf;

    // rs read: r0 is hard zero, a writeback to the same register wins
    always_comb begin
        w_rs_rf = 32'h0;
        if (w_rs != 5'd0) begin
            if (wb_we && (wb_wa == w_rs)) begin
                w_rs_rf = wb_wd;
            end else begin
                w_rs_rf = r_rf[w_rs];
            end
        end
    end

    // rt read: same policy as rs
    always_comb begin
        w_rt_rf = 32'h0;
        if (w_rt != 5'd0) begin
            if (wb_we && (wb_wa == w_rt)) begin
                w_rt_rf = wb_wd;
            end else begin
                w_rt_rf = r_rf[w_rt];
            end
        end
    end

    // ------------------------------------------------------------------
    // MEM -> ID forwarding (ALU results only; load data is not ready yet)
    // ------------------------------------------------------------------
    logic        w_mem_fwd_ok;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    assign w_mem_fwd_ok = mem_we && !mem_mem_read && (mem_wa != 5'd0);

    // Select forwarded operand values
    always_comb begin
        w_rs_val = w_rs_rf;
        w_rt_val = w_rt_rf;
        if (w_mem_fwd_ok && (mem_wa == w_rs)) begin
            w_rs_val = mem_alu;
        end
        if (w_mem_fwd_ok && (mem_wa == w_rt)) begin
            w_rt_val = mem_alu;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic w_load_use;
    logic w_ex_dep;
    logic w_mem_dep;
    logic w_stall;

    // Compute the three stall sources; only a valid latch can stall
    always_comb begin
        // A load in EX feeding any rs/rt field of the instruction in ID
        w_load_use = ex_mem_read && (ex_wa != 5'd0) &&
                     ((ex_wa == w_rs) || (ex_wa == w_rt));

        // Any result still in EX cannot reach a branch/jr compare in time
        w_ex_dep = w_is_ctl && ex_we && (ex_wa != 5'd0) &&
                   ((w_uses_rs && (ex_wa == w_rs)) ||
                    (w_uses_rt && (ex_wa == w_rt)));

        // A load in MEM has no data available for ID forwarding yet
        w_mem_dep = w_is_ctl && mem_mem_read && (mem_wa != 5'd0) &&
                    ((w_uses_rs && (mem_wa == w_rs)) ||
                     (w_uses_rt && (mem_wa == w_rt)));

        w_stall = r_valid && (w_load_use || w_ex_dep || w_mem_dep);
    end

    // ------------------------------------------------------------------
    // Branch / jump resolution
    // ------------------------------------------------------------------
    logic [1:0] w_pcsrc;
    logic       w_rs_eq;

    assign w_rs_eq = (w_rs_val == w_rt_val);

    // Choose the next-PC source; a stalled or invalid latch never redirects
    always_comb begin
        w_pcsrc = c_PC_SEQ;
        if (r_valid && !w_stall) begin
            if ((w_is_beq && w_rs_eq) || (w_is_bne && !w_rs_eq)) begin
                w_pcsrc = c_PC_BRANCH;
            end else if (w_is_jr) begin
                w_pcsrc = c_PC_JR;
            end else if (w_is_jump) begin
                w_pcsrc = c_PC_JUMP;
            end
        end
    end

    // ------------------------------------------------------------------
    // IF/ID latch: hold on stall, squash the wrong-path fetch on redirect
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ins   <= NOP_INS;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (!w_stall) begin
            r_pc4 <= if_pc4;
            if (w_pcsrc != c_PC_SEQ) begin
                r_ins   <= NOP_INS;
                r_valid <= 1'b0;
            end else begin
                r_ins   <= if_ins;
                r_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file write port; r0 is never written
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'h0;
            end
        end else if (wb_we && (wb_wa != 5'd0)) begin
            r_rf[wb_wa] <= wb_wd;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bpc        = r_pc4 + {w_imm[29:0], 2'b00};
    assign rpc        = w_rs_val;
    assign jpc        = {r_pc4[31:28], r_ins[25:0], 2'b00};
    assign PCSrc      = w_pcsrc;
    assign pc_we      = !w_stall;
    assign id_valid   = r_valid && !w_stall;
    assign id_ins     = r_ins;
    assign id_pc4     = r_pc4;
    assign id_rs_data = w_rs_val;
    assign id_rt_data = w_rt_val;
    assign id_imm     = w_imm;

endmodule
`default_nettype wire
